// File: rtl/riscv_soft_fetch_pkg.sv
// riscv_soft_fetch_pkg: shared constants for the fetch stage.
package riscv_soft_fetch_pkg;
  localparam int INST_LEN = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0200;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PC_INC = 4;
endpackage

// File: rtl/riscv_soft_fetch_if.sv
// riscv_soft_fetch_if: I-cache request/response, EX redirect and core instruction handshakes.
interface riscv_soft_fetch_if
  import riscv_soft_fetch_pkg::*;
#(
  parameter int XPR_LEN = 32
);
  logic                i_cache_req_ready;
  logic                i_cache_req_valid;
  logic [XPR_LEN-1:0]  i_cache_req_addr;
  logic                i_cache_resp_valid;
  logic [INST_LEN-1:0] i_cache_resp_data;
  logic                redirect_valid;
  logic [XPR_LEN-1:0]  redirect_pc;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst_data;
  logic [XPR_LEN-1:0]  inst_pc;
  modport master (
    input  i_cache_req_ready, i_cache_resp_valid, i_cache_resp_data, redirect_valid, redirect_pc, inst_ready,
    output i_cache_req_valid, i_cache_req_addr, inst_valid, inst_data, inst_pc
  );
  modport slave (
    output i_cache_req_ready, i_cache_resp_valid, i_cache_resp_data, redirect_valid, redirect_pc, inst_ready,
    input  i_cache_req_valid, i_cache_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/riscv_soft_fetch_fifo.sv
// riscv_soft_fetch_fifo: flushable sync FIFO with same-cycle push/pop at any occupancy.
module riscv_soft_fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/riscv_soft_fetch.sv
// riscv_soft_fetch: credit-limited sequential I-fetch with flushable response buffer and redirect.
// Define RISCV_SOFT_FETCH_BYPASS_EN to forward a kept response straight to the core when the buffer is empty.
module riscv_soft_fetch
  import riscv_soft_fetch_pkg::*;
#(
  parameter int XPR_LEN = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(RESET_PC_DEF),
  parameter int FETCH_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  riscv_soft_fetch_if.master bus_io
);
  localparam int CW = $clog2(FETCH_DEPTH) + 1;
  localparam logic [XPR_LEN-1:0] INC = XPR_LEN'(PC_INC);
  logic [XPR_LEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt;
  logic [XPR_LEN+INST_LEN-1:0] head;
  logic redir, fire, resp, dec, keep, push, pop, empty, byp;
  assign redir = bus_io.redirect_valid;
  assign target = {bus_io.redirect_pc[XPR_LEN-1:2], 2'b00};
  assign resp = bus_io.i_cache_resp_valid;
  assign dec = resp && out_q != '0;
  assign keep = resp && drop_q == '0;
  assign fire = bus_io.i_cache_req_valid && bus_io.i_cache_req_ready;
  assign bus_io.i_cache_req_valid = reset && !redir &&
                                    ({1'b0, cnt} + {1'b0, out_q} < (CW+1)'(FETCH_DEPTH));
  assign bus_io.i_cache_req_addr = reset ? fetch_pc_q : RESET_PC;
`ifdef RISCV_SOFT_FETCH_BYPASS_EN
  assign byp = empty && keep && !redir;
`else
  assign byp = 1'b0;
`endif
  assign bus_io.inst_valid = reset && (!empty || byp);
  assign {bus_io.inst_pc, bus_io.inst_data} = !reset ? '0 :
                                              empty ? {resp_pc_q, bus_io.i_cache_resp_data} : head;
  assign pop = bus_io.inst_valid && bus_io.inst_ready && !empty && !redir;
  assign push = keep && !redir && !(byp && bus_io.inst_ready);
  riscv_soft_fetch_fifo #(.W(XPR_LEN + INST_LEN), .DEPTH(FETCH_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush_i(redir),
    .push_i(push),
    .pop_i(pop),
    .din_i({resp_pc_q, bus_io.i_cache_resp_data}),
    .dout_o(head),
    .count_o(cnt),
    .empty_o(empty)
  );
  // A redirect turns every request still in flight (minus the one landing now) into a stale drop.
  always_comb begin
    out_d = out_q + CW'(fire) - CW'(dec);
    drop_d = redir ? out_q - CW'(dec) : drop_q - CW'(resp && drop_q != '0);
    fetch_pc_d = redir ? target : fire ? fetch_pc_q + INC : fetch_pc_q;
    resp_pc_d = redir ? target : keep ? resp_pc_q + INC : resp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  assert property (@(posedge clk) disable iff (!reset) !(resp && out_q == '0));
endmodule

// File: tb/tb_riscv_soft_fetch.sv
// tb_riscv_soft_fetch: directed fetch scenarios against an in-order I-cache model and instruction scoreboard.
module tb_riscv_soft_fetch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_soft_fetch_if #(.XPR_LEN(32)) bus ();
  riscv_soft_fetch #(.XPR_LEN(32), .RESET_PC(32'h200), .FETCH_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(bus)
  );

`ifdef RISCV_SOFT_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] pa[$];
  int pd[$];
  logic [63:0] exp_q[$];
  logic [31:0] seen[$];
  logic [31:0] reqs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    seen.delete();
    reqs.delete();
  endtask

  // In-order cache: a request accepted in cycle c answers in cycle c+lat.
  initial begin
    bus.i_cache_resp_valid = 1'b0;
    bus.i_cache_resp_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pa.size() != 0 && pd[0] <= cyc) begin
        bus.i_cache_resp_valid = 1'b1;
        bus.i_cache_resp_data = mem_word(pa[0]);
      end else begin
        bus.i_cache_resp_valid = 1'b0;
        bus.i_cache_resp_data = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pa.delete();
      pd.delete();
      exp_q.delete();
    end else begin
      if (bus.i_cache_resp_valid) begin
        void'(pa.pop_front());
        void'(pd.pop_front());
      end
      if (bus.redirect_valid) exp_q.delete();
      else if (bus.inst_valid && bus.inst_ready) begin
        seen.push_back(bus.inst_pc);
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else chk("sb_inst", {bus.inst_pc, bus.inst_data}, exp_q.pop_front());
      end
      if (bus.i_cache_req_valid && bus.i_cache_req_ready) begin
        reqs.push_back(bus.i_cache_req_addr);
        pa.push_back(bus.i_cache_req_addr);
        pd.push_back(cyc + lat);
        exp_q.push_back({bus.i_cache_req_addr, mem_word(bus.i_cache_req_addr)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cache_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;
    step(3);
    chk("rst_req_valid", bus.i_cache_req_valid, 0);
    chk("rst_req_addr", bus.i_cache_req_addr, 32'h200);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_inst_data", bus.inst_data, 0);

    bus.i_cache_req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    lat = 1;
    clr();
    reset = 1'b1;
    #1;
    chk("t1_req_valid", bus.i_cache_req_valid, 1);
    chk("t1_req_addr", bus.i_cache_req_addr, 32'h200);
    step(1);
    chk("t1_resp_lat", bus.inst_valid, BYP);
    step(11);
    for (int i = 0; i < 4; i++) chk("t1_req", reqs[i], 32'h200 + 4 * i);
    chk("t1_count", seen.size(), BYP ? 11 : 10);
    for (int i = 0; i < 8; i++) chk("t1_pc", seen[i], 32'h200 + 4 * i);

    reset = 1'b0;
    step(1);
    bus.inst_ready = 1'b0;
    clr();
    reset = 1'b1;
    step(10);
    chk("t2_nreq", reqs.size(), 4);
    chk("t2_req_valid", bus.i_cache_req_valid, 0);
    chk("t2_inst_valid", bus.inst_valid, 1);
    chk("t2_head_pc", bus.inst_pc, 32'h200);
    bus.inst_ready = 1'b1;
    step(10);
    for (int i = 0; i < 4; i++) chk("t2_pc", seen[i], 32'h200 + 4 * i);
    chk("t2_resume", reqs[4], 32'h210);

    reset = 1'b0;
    step(1);
    lat = 3;
    clr();
    reset = 1'b1;
    step(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h1003;
    #1;
    chk("t3_redir_blocks_req", bus.i_cache_req_valid, 0);
    chk("t3_inflight", reqs.size(), 2);
    step(1);
    clr();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_req_addr", bus.i_cache_req_addr, 32'h1000);
    chk("t3_req_valid", bus.i_cache_req_valid, 1);
    step(1);
    chk("t3_drop", bus.inst_valid, 0);
    step(7);
    chk("t3_first_req", reqs[0], 32'h1000);
    chk("t3_pc0", seen[0], 32'h1000);
    chk("t3_pc1", seen[1], 32'h1004);

    reset = 1'b0;
    step(1);
    lat = 2;
    clr();
    reset = 1'b1;
    step(5);
    chk("t4_pre_valid", bus.inst_valid, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3002;
    #1;
    chk("t4_redir_req_valid", bus.i_cache_req_valid, 0);
    step(1);
    clr();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_no_stale", bus.inst_valid, 0);
    chk("t4_req_addr", bus.i_cache_req_addr, 32'h3000);
    step(8);
    chk("t4_pc0", seen[0], 32'h3000);
    chk("t4_pc1", seen[1], 32'h3004);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step(1);
    clr();
    bus.redirect_valid = 1'b0;
    step(10);
    chk("t5_pc0", seen[0], 32'hFFFF_FFF8);
    chk("t5_pc1", seen[1], 32'hFFFF_FFFC);
    chk("t5_pc2", seen[2], 32'h0);
    chk("t5_req_wrap", reqs[2], 32'h0);

    bus.inst_ready = 1'b0;
    step(4);
    chk("t6_buffered", bus.inst_valid, 1);
    reset = 1'b0;
    #1;
    chk("t6_inst_valid_now", bus.inst_valid, 0);
    chk("t6_req_valid_now", bus.i_cache_req_valid, 0);
    step(1);
    chk("t6_inst_valid", bus.inst_valid, 0);
    chk("t6_req_addr_rst", bus.i_cache_req_addr, 32'h200);
    lat = 1;
    bus.inst_ready = 1'b1;
    clr();
    reset = 1'b1;
    #1;
    chk("t6_req_addr", bus.i_cache_req_addr, 32'h200);
    chk("t6_req_valid", bus.i_cache_req_valid, 1);
    step(6);
    chk("t6_first_req", reqs[0], 32'h200);
    chk("t6_pc0", seen[0], 32'h200);
    chk("t6_pc1", seen[1], 32'h204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
